// File: rtl/fetch_pc_gen_pkg.sv
// Shared definitions for the fetch PC generator slice.
// Provides default bus widths, the flush vector width, the reset PC,
// the fetch sequencer state encoding and a PC alignment helper.
package fetch_pc_gen_pkg;

    localparam int          ADDR_W       = 32;
    localparam int          INST_W       = 32;
    localparam int          FLUSH_W      = 5;
    localparam logic [31:0] RESET_PC_DEF = 32'h1c00_0000;

    typedef enum logic [2:0] {
        BOOT = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        HOLD = 3'd3,
        ADEF = 3'd4
    } fetch_state_e;

    // A fetch address is legal only when word aligned.
    function automatic logic pc_misaligned(input logic [1:0] pc_lo);
        return (pc_lo != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_out_buf.sv
// Output register between fetch and decode.
// Holds one {pc, inst, adef} slot and its valid flag. A load always wins
// over a drop so that leaving one slot and entering an address-error slot
// on the same edge presents the new slot.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   load                  capture in_pc/in_inst/in_adef and set valid
//   drop                  clear the slot (consumed or flushed)
//   in_pc/in_inst/in_adef slot contents to capture
//   if_valid/if_pc/if_inst/if_adef  registered slot presented to decode
module fetch_out_buf
    import fetch_pc_gen_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W,
    parameter int INST_WIDTH = INST_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic                  drop,
    input  logic [ADDR_WIDTH-1:0] in_pc,
    input  logic [INST_WIDTH-1:0] in_inst,
    input  logic                  in_adef,
    output logic                  if_valid,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [INST_WIDTH-1:0] if_inst,
    output logic                  if_adef
);

    // Slot register: load has priority over drop, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid <= 1'b0;
            if_pc    <= {ADDR_WIDTH{1'b0}};
            if_inst  <= {INST_WIDTH{1'b0}};
            if_adef  <= 1'b0;
        end else if (load) begin
            if_valid <= 1'b1;
            if_pc    <= in_pc;
            if_inst  <= in_inst;
            if_adef  <= in_adef;
        end else if (drop) begin
            if_valid <= 1'b0;
            if_pc    <= {ADDR_WIDTH{1'b0}};
            if_inst  <= {INST_WIDTH{1'b0}};
            if_adef  <= 1'b0;
        end else begin
            if_valid <= if_valid;
            if_pc    <= if_pc;
            if_inst  <= if_inst;
            if_adef  <= if_adef;
        end
    end

endmodule

// File: rtl/fetch_pc_gen_chk.sv
// Protocol checker for the fetch instruction bus.
// Ports: clk, rst_n, current fetch state and the instruction bus handshake.
module fetch_pc_gen_chk
    import fetch_pc_gen_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_W
) (
    input logic                  clk,
    input logic                  rst_n,
    input fetch_state_e          state,
    input logic                  inst_req,
    input logic [ADDR_WIDTH-1:0] inst_addr,
    input logic                  inst_addr_ok,
    input logic                  inst_data_ok
);

    // Only one transaction can be outstanding, so a response belongs in WAIT.
    a_data_ok_in_wait: assert property (@(posedge clk) disable iff (!rst_n)
        inst_data_ok |-> (state == WAIT));

    // An unaccepted request must keep its address until accepted.
    a_addr_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (inst_req && !inst_addr_ok) |=> (inst_req && $stable(inst_addr)));

endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch-stage PC generator and instruction-fetch sequencer.
// Owns the fetch PC, issues one request at a time on the instruction bus,
// discards responses made stale by a redirect and presents instructions
// to decode through fetch_out_buf.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   flush, flush_pc            redirect request (any flush bit) and target
//   bp_taken, bp_target        prediction for the instruction being consumed
//   inst_req, inst_addr        registered bus request
//   inst_addr_ok, inst_data_ok, inst_rdata   bus handshake and response
//   id_allowin                 decode accepts the presented slot
//   if_valid, if_pc, if_inst, if_adef        slot presented to decode
module fetch_pc_gen
    import fetch_pc_gen_pkg::*;
#(
    parameter int                    ADDR_WIDTH = ADDR_W,
    parameter int                    INST_WIDTH = INST_W,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(RESET_PC_DEF)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [FLUSH_W-1:0]    flush,
    input  logic [ADDR_WIDTH-1:0] flush_pc,
    input  logic                  bp_taken,
    input  logic [ADDR_WIDTH-1:0] bp_target,
    output logic                  inst_req,
    output logic [ADDR_WIDTH-1:0] inst_addr,
    input  logic                  inst_addr_ok,
    input  logic                  inst_data_ok,
    input  logic [INST_WIDTH-1:0] inst_rdata,
    input  logic                  id_allowin,
    output logic                  if_valid,
    output logic [ADDR_WIDTH-1:0] if_pc,
    output logic [INST_WIDTH-1:0] if_inst,
    output logic                  if_adef
);

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(3'd4);

    fetch_state_e          state_r, state_nxt_s;
    logic [ADDR_WIDTH-1:0] pc_r, pc_nxt_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_nxt_s;
    logic                  req_r, req_nxt_s;
    logic                  cancel_r, cancel_nxt_s;
    logic                  pend_r, pend_nxt_s;

    logic                  redirect_s;
    logic                  go_s;
    logic [ADDR_WIDTH-1:0] target_s;
    logic                  misalign_s;
    logic                  buf_load_s, buf_drop_s, buf_adef_s;
    logic [ADDR_WIDTH-1:0] buf_pc_s;
    logic [INST_WIDTH-1:0] buf_inst_s;

    assign redirect_s = (flush != {FLUSH_W{1'b0}});
    assign inst_req   = req_r;
    assign inst_addr  = addr_r;

    // Address used when (re)entering the request phase from the current state.
    always_comb begin
        target_s = pc_r;
        case (state_r)
            BOOT, WAIT: target_s = redirect_s ? flush_pc : pc_r;
            HOLD, ADEF: target_s = redirect_s ? flush_pc
                                 : (bp_taken ? bp_target : (if_pc + PC_STEP));
            default:    target_s = pc_r;
        endcase
        misalign_s = pc_misaligned(target_s[1:0]);
    end

    // Fetch sequencer next-state, bus request and output-slot control.
    always_comb begin
        state_nxt_s  = state_r;
        pc_nxt_s     = pc_r;
        addr_nxt_s   = addr_r;
        req_nxt_s    = req_r;
        cancel_nxt_s = cancel_r;
        pend_nxt_s   = pend_r;
        go_s         = 1'b0;
        buf_load_s   = 1'b0;
        buf_drop_s   = 1'b0;
        buf_adef_s   = 1'b0;
        buf_pc_s     = pc_r;
        buf_inst_s   = {INST_WIDTH{1'b0}};

        case (state_r)
            BOOT: begin
                go_s = 1'b1;
            end
            REQ: begin
                // The pending request keeps its address; only pc moves.
                pc_nxt_s = redirect_s ? flush_pc : pc_r;
                if (inst_addr_ok) begin
                    state_nxt_s  = WAIT;
                    req_nxt_s    = 1'b0;
                    cancel_nxt_s = redirect_s | pend_r;
                    pend_nxt_s   = 1'b0;
                end else begin
                    pend_nxt_s   = pend_r | redirect_s;
                end
            end
            WAIT: begin
                if (inst_data_ok) begin
                    if (cancel_r || redirect_s) begin
                        cancel_nxt_s = 1'b0;
                        go_s         = 1'b1;
                    end else begin
                        buf_load_s  = 1'b1;
                        buf_pc_s    = pc_r;
                        buf_inst_s  = inst_rdata;
                        state_nxt_s = HOLD;
                    end
                end else if (redirect_s) begin
                    cancel_nxt_s = 1'b1;
                    pc_nxt_s     = flush_pc;
                end else begin
                    cancel_nxt_s = cancel_r;
                end
            end
            HOLD, ADEF: begin
                if (redirect_s || id_allowin) begin
                    buf_drop_s = 1'b1;
                    go_s       = 1'b1;
                end else begin
                    buf_drop_s = 1'b0;
                end
            end
            default: begin
                state_nxt_s  = BOOT;
                req_nxt_s    = 1'b0;
                cancel_nxt_s = 1'b0;
                pend_nxt_s   = 1'b0;
            end
        endcase

        // Entering the request phase: a misaligned target becomes an
        // address-error slot instead of a bus request.
        if (go_s) begin
            pc_nxt_s    = target_s;
            addr_nxt_s  = target_s;
            pend_nxt_s  = 1'b0;
            state_nxt_s = misalign_s ? ADEF : REQ;
            req_nxt_s   = ~misalign_s;
            buf_load_s  = misalign_s;
            buf_adef_s  = misalign_s;
            buf_pc_s    = target_s;
            buf_inst_s  = {INST_WIDTH{1'b0}};
        end else begin
            buf_adef_s  = 1'b0;
        end
    end

    // Sequencer state, fetch PC and registered bus request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= BOOT;
            pc_r     <= RESET_PC;
            addr_r   <= RESET_PC;
            req_r    <= 1'b0;
            cancel_r <= 1'b0;
            pend_r   <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            pc_r     <= pc_nxt_s;
            addr_r   <= addr_nxt_s;
            req_r    <= req_nxt_s;
            cancel_r <= cancel_nxt_s;
            pend_r   <= pend_nxt_s;
        end
    end

    fetch_out_buf #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .INST_WIDTH (INST_WIDTH)
    ) u_out_buf (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (buf_load_s),
        .drop     (buf_drop_s),
        .in_pc    (buf_pc_s),
        .in_inst  (buf_inst_s),
        .in_adef  (buf_adef_s),
        .if_valid (if_valid),
        .if_pc    (if_pc),
        .if_inst  (if_inst),
        .if_adef  (if_adef)
    );

    fetch_pc_gen_chk #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_chk (
        .clk          (clk),
        .rst_n        (rst_n),
        .state        (state_r),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok)
    );

endmodule

// File: tb/tb_fetch_pc_gen.sv
// Directed bench for fetch_pc_gen. Inputs change 1 time unit after the
// rising edge; outputs are sampled at the same point.
module tb_fetch_pc_gen;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  flush;
    logic [31:0] flush_pc;
    logic        bp_taken;
    logic [31:0] bp_target;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok;
    logic        inst_data_ok;
    logic [31:0] inst_rdata;
    logic        id_allowin;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_adef;

    int vec_cnt = 0;
    int err_cnt = 0;

    fetch_pc_gen dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .flush_pc     (flush_pc),
        .bp_taken     (bp_taken),
        .bp_target    (bp_target),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .id_allowin   (id_allowin),
        .if_valid     (if_valid),
        .if_pc        (if_pc),
        .if_inst      (if_inst),
        .if_adef      (if_adef)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 5'd0; flush_pc = 32'd0; bp_taken = 1'b0;
        bp_target = 32'd0; inst_addr_ok = 1'b0; inst_data_ok = 1'b0;
        inst_rdata = 32'd0; id_allowin = 1'b0;
        tick(); tick();
        vec_cnt++; if (inst_req !== 1'b0) begin err_cnt++; $display("FAIL rst_req: got %0b want 0", inst_req); end
        vec_cnt++; if (inst_addr !== 32'h1c00_0000) begin err_cnt++; $display("FAIL rst_addr: got %h want 1c000000", inst_addr); end
        vec_cnt++; if ({if_valid, if_adef} !== 2'b00) begin err_cnt++; $display("FAIL rst_valid_adef: got %b want 00", {if_valid, if_adef}); end
        vec_cnt++; if ({if_pc, if_inst} !== 64'd0) begin err_cnt++; $display("FAIL rst_pc_inst: got %h want 0", {if_pc, if_inst}); end
        rst_n = 1'b1;
        tick();
        vec_cnt++; if ({inst_req, inst_addr} !== {1'b1, 32'h1c00_0000}) begin err_cnt++; $display("FAIL boot_req: got %b/%h want 1/1c000000", inst_req, inst_addr); end
    endtask

    task automatic test_basic();
        inst_addr_ok = 1'b1;
        tick();
        vec_cnt++; if (inst_req !== 1'b0) begin err_cnt++; $display("FAIL basic_wait_req: got %0b want 0", inst_req); end
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h0280_0000; id_allowin = 1'b1;
        tick();
        vec_cnt++; if ({if_valid, if_adef} !== 2'b10) begin err_cnt++; $display("FAIL basic_valid: got %b want 10", {if_valid, if_adef}); end
        vec_cnt++; if ({if_pc, if_inst} !== {32'h1c00_0000, 32'h0280_0000}) begin err_cnt++; $display("FAIL basic_slot: got %h want 1c00000002800000", {if_pc, if_inst}); end
        inst_data_ok = 1'b0;
        tick();
        vec_cnt++; if ({inst_req, inst_addr, if_valid} !== {1'b1, 32'h1c00_0004, 1'b0}) begin err_cnt++; $display("FAIL basic_next: got %b/%h/%b want 1/1c000004/0", inst_req, inst_addr, if_valid); end
        id_allowin = 1'b0;
    endtask

    task automatic test_flush_req();
        flush = 5'b00001; flush_pc = 32'h1c00_0100;
        for (int i = 0; i < 3; i++) begin
            tick();
            flush = 5'd0;
            vec_cnt++; if ({inst_req, inst_addr} !== {1'b1, 32'h1c00_0004}) begin err_cnt++; $display("FAIL req_hold_%0d: got %b/%h want 1/1c000004", i, inst_req, inst_addr); end
        end
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h1111_1111;
        tick();
        inst_data_ok = 1'b0;
        vec_cnt++; if ({inst_req, inst_addr, if_valid} !== {1'b1, 32'h1c00_0100, 1'b0}) begin err_cnt++; $display("FAIL req_reissue: got %b/%h/%b want 1/1c000100/0", inst_req, inst_addr, if_valid); end
    endtask

    task automatic test_flush_wait();
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; flush = 5'b10000; flush_pc = 32'h1c00_0200;
        tick();
        vec_cnt++; if (inst_req !== 1'b0) begin err_cnt++; $display("FAIL wait_flush_req: got %0b want 0", inst_req); end
        flush = 5'd0; inst_data_ok = 1'b1; inst_rdata = 32'hdead_beef;
        tick();
        inst_data_ok = 1'b0;
        vec_cnt++; if ({inst_req, inst_addr, if_valid} !== {1'b1, 32'h1c00_0200, 1'b0}) begin err_cnt++; $display("FAIL wait_flush_next: got %b/%h/%b want 1/1c000200/0", inst_req, inst_addr, if_valid); end
    endtask

    task automatic test_hold_stall();
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h1234_5678;
        tick();
        inst_data_ok = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vec_cnt++; if ({if_valid, inst_req, if_pc, if_inst} !== {1'b1, 1'b0, 32'h1c00_0200, 32'h1234_5678}) begin err_cnt++; $display("FAIL hold_stall_%0d: got %b/%b/%h/%h want 1/0/1c000200/12345678", i, if_valid, inst_req, if_pc, if_inst); end
            tick();
        end
        id_allowin = 1'b1; bp_taken = 1'b1; bp_target = 32'h1c00_0040;
        tick();
        id_allowin = 1'b0; bp_taken = 1'b0;
        vec_cnt++; if ({inst_req, inst_addr, if_valid} !== {1'b1, 32'h1c00_0040, 1'b0}) begin err_cnt++; $display("FAIL hold_bp: got %b/%h/%b want 1/1c000040/0", inst_req, inst_addr, if_valid); end
    endtask

    task automatic test_back_to_back();
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'h5555_aaaa;
        flush = 5'b00100; flush_pc = 32'h1c00_0300;
        tick();
        inst_data_ok = 1'b0; flush = 5'd0;
        vec_cnt++; if ({inst_req, inst_addr, if_valid} !== {1'b1, 32'h1c00_0300, 1'b0}) begin err_cnt++; $display("FAIL same_cycle: got %b/%h/%b want 1/1c000300/0", inst_req, inst_addr, if_valid); end
    endtask

    task automatic test_adef();
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; flush = 5'b00001; flush_pc = 32'h1c00_0002;
        tick();
        flush = 5'd0; inst_data_ok = 1'b1;
        tick();
        inst_data_ok = 1'b0;
        vec_cnt++; if ({inst_req, if_valid, if_adef} !== 3'b011) begin err_cnt++; $display("FAIL adef_flags: got %b want 011", {inst_req, if_valid, if_adef}); end
        vec_cnt++; if ({if_pc, if_inst} !== {32'h1c00_0002, 32'd0}) begin err_cnt++; $display("FAIL adef_slot: got %h want 1c00000200000000", {if_pc, if_inst}); end
        tick();
        vec_cnt++; if ({inst_req, if_valid, if_pc} !== {1'b0, 1'b1, 32'h1c00_0002}) begin err_cnt++; $display("FAIL adef_stall: got %b/%b/%h want 0/1/1c000002", inst_req, if_valid, if_pc); end
        id_allowin = 1'b1;
        tick();
        vec_cnt++; if ({if_valid, if_adef, if_pc} !== {2'b11, 32'h1c00_0006}) begin err_cnt++; $display("FAIL adef_step: got %b/%b/%h want 1/1/1c000006", if_valid, if_adef, if_pc); end
        flush = 5'b01000; flush_pc = 32'h1c00_0010;
        tick();
        flush = 5'd0; id_allowin = 1'b0;
        vec_cnt++; if ({inst_req, inst_addr, if_valid, if_adef} !== {1'b1, 32'h1c00_0010, 2'b00}) begin err_cnt++; $display("FAIL adef_exit: got %b/%h/%b/%b want 1/1c000010/0/0", inst_req, inst_addr, if_valid, if_adef); end
    endtask

    task automatic test_wrap();
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; flush = 5'b00010; flush_pc = 32'hffff_fffc;
        tick();
        inst_data_ok = 1'b0; flush = 5'd0;
        vec_cnt++; if ({inst_req, inst_addr} !== {1'b1, 32'hffff_fffc}) begin err_cnt++; $display("FAIL wrap_req: got %b/%h want 1/fffffffc", inst_req, inst_addr); end
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0; inst_data_ok = 1'b1; inst_rdata = 32'haaaa_5555;
        tick();
        inst_data_ok = 1'b0;
        vec_cnt++; if ({if_valid, if_pc, if_inst} !== {1'b1, 32'hffff_fffc, 32'haaaa_5555}) begin err_cnt++; $display("FAIL wrap_slot: got %b/%h/%h want 1/fffffffc/aaaa5555", if_valid, if_pc, if_inst); end
        id_allowin = 1'b1;
        tick();
        id_allowin = 1'b0;
        vec_cnt++; if ({inst_req, inst_addr} !== {1'b1, 32'h0000_0000}) begin err_cnt++; $display("FAIL wrap_next: got %b/%h want 1/00000000", inst_req, inst_addr); end
    endtask

    task automatic test_reset_mid();
        inst_addr_ok = 1'b1;
        tick();
        inst_addr_ok = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        vec_cnt++; if ({inst_req, inst_addr, if_valid} !== {1'b0, 32'h1c00_0000, 1'b0}) begin err_cnt++; $display("FAIL mid_rst: got %b/%h/%b want 0/1c000000/0", inst_req, inst_addr, if_valid); end
        tick();
        rst_n = 1'b1;
        tick();
        vec_cnt++; if ({inst_req, inst_addr} !== {1'b1, 32'h1c00_0000}) begin err_cnt++; $display("FAIL mid_rst_boot: got %b/%h want 1/1c000000", inst_req, inst_addr); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_flush_req();
        test_flush_wait();
        test_hold_stall();
        test_back_to_back();
        test_adef();
        test_wrap();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
Fetch-stage PC generator and instruction-fetch sequencer. It is the consumer of the pipeline flush/redirect pair produced by the pipeline controller. It owns the architectural fetch PC, issues requests on the SRAM-like instruction bus with at most one outstanding, and discards responses made stale by a redirect. It delivers valid instruction/PC pairs to the decode stage under a valid/allowin handshake.

Parameters:
ADDR_WIDTH, 32, PC and bus address width
INST_WIDTH, 32, instruction word width
RESET_PC, 32'h1c00_0000, first fetch address after reset

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
flush  in  5  per-stage flush vector from pipeline controller; any nonzero bit = redirect
flush_pc  in  ADDR_WIDTH  redirect target, valid when flush != 0
bp_taken  in  1  predictor says delivered instruction is a taken branch
bp_target  in  ADDR_WIDTH  predicted target, valid with bp_taken
inst_req  out  1  instruction bus request
inst_addr  out  ADDR_WIDTH  request address, stable while inst_req && !inst_addr_ok
inst_addr_ok  in  1  request accepted this cycle
inst_data_ok  in  1  response data valid this cycle
inst_rdata  in  INST_WIDTH  response data
id_allowin  in  1  decode accepts a new instruction this cycle
if_valid  out  1  instruction presented to decode
if_pc  out  ADDR_WIDTH  PC of presented instruction
if_inst  out  INST_WIDTH  presented instruction
if_adef  out  1  presented slot is an address-error (pc[1:0]!=0), if_inst = 0

Behaviour:
- Reset (async, rst_n low): state=BOOT, pc=RESET_PC, inst_req=0, inst_addr=RESET_PC, if_valid=0, if_pc=0, if_inst=0, if_adef=0, cancel=0, redirect_pend=0.
- Redirect = (flush != 0). It has priority over bp_taken and over sequential pc+4. Target is latched into pc the same edge it is seen.
- States:
  BOOT: one cycle after reset release -> REQ.
  REQ: inst_req=1, inst_addr=pc. On inst_addr_ok -> WAIT. A redirect in REQ does NOT change inst_addr. Set redirect_pend, latch flush_pc; on addr_ok set cancel=1, go WAIT. After that response drains, reissue at the latched target.
  WAIT: inst_req=0. On inst_data_ok: if cancel (or redirect this cycle) drop data, clear cancel, -> REQ at current pc. Otherwise capture {pc, inst_rdata} into output buffer, -> HOLD. A redirect in WAIT sets cancel and updates pc.
  HOLD: if_valid=1. On id_allowin && !redirect: pc <= bp_taken ? bp_target : if_pc+4, if_valid<=0, -> REQ. On redirect: if_valid<=0, pc<=flush_pc, -> REQ (buffered instruction dropped).
  ADEF: entered from REQ instead of asserting inst_req when pc[1:0]!=0. Presents if_valid=1, if_adef=1, if_pc=pc, with no bus request; leaves like HOLD.
- Latency: redirect seen at edge N -> inst_req with new address at N+1 if no transaction outstanding; otherwise the cycle after the stale data_ok.
- Minimum fetch-to-decode: addr_ok same cycle as req, data_ok next cycle -> if_valid 2 cycles after req.
- Never more than one outstanding; inst_data_ok outside WAIT is a protocol error (assertion).
- PC arithmetic modulo 2^ADDR_WIDTH; 32'hffff_fffc + 4 wraps to 0.
- Reset mid-transaction: all state cleared; a late inst_data_ok after reset release while in BOOT/REQ is ignored.

Decomposition:
- Shared package (extend width_param): ADDR_WIDTH/INST_WIDTH constants, fetch state enum {BOOT, REQ, WAIT, HOLD, ADEF}, FLUSH_W=5.
- One natural sub-module: fetch_out_buf (valid/allowin skid register holding pc/inst/adef). The FSM stays in fetch_pc_gen.

Test Plan:
- Reset release, bus addr_ok immediate, data_ok next cycle with 32'h0280_0000, id_allowin=1 -> inst_addr=1c000000 then 1c000004; if_valid with if_pc=1c000000, if_inst=02800000.
- flush=5'b10000, flush_pc=1c000100 during WAIT -> that data_ok dropped, no if_valid; next inst_req addr=1c000100.
- Redirect in REQ with addr_ok held low 3 cycles -> inst_addr stays at old value until accepted, response discarded, then request 1c000100.
- HOLD with id_allowin=0 for 4 cycles -> if_valid/if_pc/if_inst stable, no inst_req; allowin with bp_taken=1, bp_target=1c000040 -> next request 1c000040.
- Redirect and inst_data_ok same cycle in WAIT -> data dropped, next request at flush_pc.
- flush_pc=1c000002 -> no inst_req; if_valid=1, if_adef=1, if_pc=1c000002, if_inst=0.
